display_scan_mux: RTL

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_pkg.sv | 31 +++
 rtl/bcd_to_7seg.sv | 17 +
 rtl/display_scan_mux.sv | 99 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment clock display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   localparam logic [2:0] DIG_BLANK_LO   = 3'd0;
   localparam logic [2:0] DIG_SEC_UNITS  = 3'd1;
   localparam logic [2:0] DIG_SEC_TENS   = 3'd2;
   localparam logic [2:0] DIG_MIN_UNITS  = 3'd3;
   localparam logic [2:0] DIG_MIN_TENS   = 3'd4;
   localparam logic [2:0] DIG_HOUR_UNITS = 3'd5;
   localparam logic [2:0] DIG_HOUR_TENS  = 3'd6;
   localparam logic [2:0] DIG_BLANK_HI   = 3'd7;

   typedef struct packed {
      logic [3:0] hour_tens;
      logic [3:0] hour_units;
      logic [3:0] min_tens;
      logic [3:0] min_units;
      logic [3:0] sec_tens;
      logic [3:0] sec_units;
   } bcd_snap_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes show a dash; dp is always off.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan of six BCD digits over eight anode slots.
// Digits come from a per-frame snapshot so a frame never tears.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit LZ_SUPPRESS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sec_units,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_units,
   input  logic [3:0] min_tens,
   input  logic [3:0] hour_units,
   input  logic [3:0] hour_tens,
   input  logic       blank_en,
   output logic [2:0] select,
   output logic [7:0] seg_data,
   output logic [7:0] anode
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CW-1:0] cnt;
   logic          tick;
   logic [2:0]    sel_next;
   bcd_snap_t     snap;
   logic [3:0]    digit;
   logic          slot_dark;
   logic [7:0]    digit_seg;
   logic [7:0]    seg_next;
   logic [7:0]    anode_next;

   bcd_to_7seg u_dec (
      .bcd (digit),
      .seg (digit_seg)
   );

   always_comb begin
      tick     = (cnt == CNT_MAX);
      sel_next = tick ? select + 3'd1 : select;
   end

   // Outputs are decoded from the slot being entered so all three
   // registers land together.
   always_comb begin
      digit     = 4'h0;
      slot_dark = 1'b0;
      unique case (sel_next)
         DIG_SEC_UNITS:  digit = snap.sec_units;
         DIG_SEC_TENS:   digit = snap.sec_tens;
         DIG_MIN_UNITS:  digit = snap.min_units;
         DIG_MIN_TENS:   digit = snap.min_tens;
         DIG_HOUR_UNITS: digit = snap.hour_units;
         DIG_HOUR_TENS:  digit = snap.hour_tens;
         default:        slot_dark = 1'b1;
      endcase
   end

   always_comb begin
      seg_next = digit_seg;
      if (slot_dark) begin
         seg_next = SEG_BLANK;
      end
      if (LZ_SUPPRESS && sel_next == DIG_HOUR_TENS
          && snap.hour_tens == 4'h0) begin
         seg_next = SEG_BLANK;
      end
      seg_next[7] = 1'b1;
      anode_next  = blank_en ? 8'hFF : ~(8'h01 << sel_next);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         select   <= DIG_BLANK_LO;
         anode    <= 8'hFE;
         seg_data <= SEG_BLANK;
         snap     <= '0;
      end else begin
         cnt      <= tick ? '0 : cnt + CNT_ONE;
         select   <= sel_next;
         anode    <= anode_next;
         seg_data <= seg_next;
         if (tick && select == DIG_BLANK_HI) begin
            snap <= '{hour_tens:  hour_tens,
                      hour_units: hour_units,
                      min_tens:   min_tens,
                      min_units:  min_units,
                      sec_tens:   sec_tens,
                      sec_units:  sec_units};
         end
      end
   end

endmodule
